l3_resolver: RTL and testbench

Sequential carry-resolver that converts an L3 redundant polynomial, the accumulator format produced by the post-adder, into a plain two's-complement integer. It consumes one digit per cycle, least significant first, and ripples a signed carry through the digits. It sits downstream of the post-adder's accumulator outputs and feeds blocks that need a non-redundant value, such as final reduction and readout. Both sides use a valid/ready handshake.

---
 rtl/l3_resolver.sv | 80 ++++++++
 tb/tb_l3_resolver.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/l3_resolver.sv
// Serial carry resolver: turns an L3 redundant polynomial into a two's-complement
// integer, one digit per cycle, LSB digit first, behind valid/ready on both sides.
module l3_resolver #(
  parameter int ADD_DIV  = 4,
  parameter int DIGIT_W  = 16,
  parameter int L3_CARRY = 8
) (
  input  logic                                   clk,
  input  logic                                   rstn,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [ADD_DIV*(L3_CARRY+DIGIT_W)-1:0]  in_L3,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [ADD_DIV*DIGIT_W+L3_CARRY-1:0]    out_int
);

  localparam int DT  = L3_CARRY + DIGIT_W;
  localparam int LEN = ADD_DIV*DIGIT_W + L3_CARRY;
  localparam int KW  = (ADD_DIV > 1) ? $clog2(ADD_DIV) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t              state;
  logic [ADD_DIV*DT-1:0] op;
  logic [L3_CARRY:0]   c;
  logic [KW-1:0]       k;
  logic [DT-1:0]       digit;
  logic [DT:0]         s;
  logic [L3_CARRY:0]   c_next;
  logic                accept;

  always_comb begin
    in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
    out_valid = (state == DONE);
    accept    = in_valid && in_ready;
  end

  // One extra bit on the sum keeps the signed carry exact; c_next is s >>> DIGIT_W.
  always_comb begin
    digit  = op[int'(k)*DT +: DT];
    s      = {{DIGIT_W{c[L3_CARRY]}}, c} + {digit[DT-1], digit};
    c_next = s[DT:DIGIT_W];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      op      <= '0;
      c       <= '0;
      k       <= '0;
      out_int <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            op    <= in_L3;
            c     <= '0;
            k     <= '0;
            state <= RUN;
          end else if (state == DONE && out_ready) begin
            state <= IDLE;
          end
        end
        RUN: begin
          out_int[int'(k)*DIGIT_W +: DIGIT_W] <= s[DIGIT_W-1:0];
          c <= c_next;
          if (k == KW'(ADD_DIV-1)) begin
            out_int[LEN-1 -: L3_CARRY] <= c_next[L3_CARRY-1:0];
            state <= DONE;
          end else begin
            k <= k + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_l3_resolver.sv
// Directed and randomized checks of l3_resolver against an arithmetic model
// (sum of sign-extended weighted digits modulo 2^LEN).
module tb_l3_resolver;

  localparam int AD  = 4;
  localparam int DW  = 8;
  localparam int LC  = 4;
  localparam int DT  = LC + DW;
  localparam int OPW = AD*DT;
  localparam int LEN = AD*DW + LC;

  logic           clk = 1'b0;
  logic           rstn = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [OPW-1:0] in_L3 = '0;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [LEN-1:0] out_int;

  int n_checks = 0;
  int n_fail   = 0;

  l3_resolver #(.ADD_DIV(AD), .DIGIT_W(DW), .L3_CARRY(LC)) dut (
    .clk(clk), .rstn(rstn),
    .in_valid(in_valid), .in_ready(in_ready), .in_L3(in_L3),
    .out_valid(out_valid), .out_ready(out_ready), .out_int(out_int)
  );

  always #5 clk = ~clk;

  function automatic logic [LEN-1:0] model(input logic [OPW-1:0] op);
    longint acc = 0;
    for (int i = 0; i < AD; i++) begin
      logic signed [DT-1:0] d;
      d = op[i*DT +: DT];
      acc += longint'(d) * (longint'(1) << (DW*i));
    end
    return acc[LEN-1:0];
  endfunction

  function automatic logic [OPW-1:0] rand_op();
    logic [OPW-1:0] op;
    for (int i = 0; i < AD; i++) begin
      logic [3:0] cr;
      logic [7:0] v;
      cr = 4'($urandom_range(0, 15));
      v  = 8'($urandom);
      op[i*DT +: DT] = {cr, v};
    end
    return op;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called just after the accepting edge; returns with out_valid expected high.
  task automatic wait_result(input string tag, input logic [LEN-1:0] exp);
    for (int i = 0; i < AD; i++) begin
      check({tag, "_busy"}, 64'(out_valid), 64'd0);
      tick();
    end
    check({tag, "_valid"}, 64'(out_valid), 64'd1);
    check({tag, "_data"}, 64'(out_int), 64'(exp));
  endtask

  task automatic send(input string tag, input logic [OPW-1:0] op);
    in_valid = 1'b1;
    in_L3 = op;
    #1;
    check({tag, "_inrdy"}, 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    in_L3 = rand_op();
    wait_result(tag, model(op));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_drop"}, 64'(out_valid), 64'd0);
  endtask

  logic [OPW-1:0] op_a, op_b;
  logic [LEN-1:0] exp_q[$];
  int accepted, received;

  initial begin
    #2;
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_inrdy", 64'(in_ready), 64'd1);
    check("rst_data", 64'(out_int), 64'd0);
    tick();
    rstn = 1'b1;
    tick();

    // Directed vectors with fixed expectations
    send("zero", '0);
    check("zero_const", 64'(out_int), 64'h0_0000_0000);
    send("d0_1ff", {12'h000, 12'h000, 12'h000, 12'h1FF});
    check("d0_1ff_const", 64'(out_int), 64'h0_0000_01FF);
    send("ripple", {12'h1FF, 12'h1FF, 12'h1FF, 12'h1FF});
    check("ripple_const", 64'(out_int), 64'h2_0101_00FF);
    send("neg", {12'h000, 12'h000, 12'h000, 12'hF00});
    check("neg_const", 64'(out_int), 64'hF_FFFF_FF00);

    // Backpressure then back-to-back accept from DONE
    op_a = {12'h1FF, 12'h1FF, 12'h1FF, 12'h1FF};
    op_b = {12'h800, 12'h7FF, 12'h123, 12'hABC};
    in_valid = 1'b1; in_L3 = op_a;
    tick();
    in_valid = 1'b0;
    wait_result("bp", 36'h2_0101_00FF);
    in_valid = 1'b1; in_L3 = op_b;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp_inrdy", 64'(in_ready), 64'd0);
      check("bp_hold", 64'(out_int), 64'h2_0101_00FF);
      check("bp_valid", 64'(out_valid), 64'd1);
      tick();
    end
    out_ready = 1'b1;
    #1;
    check("b2b_inrdy", 64'(in_ready), 64'd1);
    tick();
    out_ready = 1'b0; in_valid = 1'b0; in_L3 = '1;
    wait_result("b2b", model(op_b));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Reset two cycles into RUN
    in_valid = 1'b1; in_L3 = op_a;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rstn = 1'b0;
    #1;
    check("mrst_valid", 64'(out_valid), 64'd0);
    check("mrst_inrdy", 64'(in_ready), 64'd1);
    check("mrst_data", 64'(out_int), 64'd0);
    tick();
    rstn = 1'b1;
    tick();
    send("post_rst", op_b);

    // Randomized traffic with an in-order scoreboard
    accepted = 0; received = 0;
    for (int cyc = 0; cyc < 15000; cyc++) begin
      in_valid  = ($urandom_range(0, 1) == 1);
      in_L3     = rand_op();
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (out_valid && out_ready) begin
        received++;
        if (exp_q.size() == 0) check("rand_spurious", 64'd1, 64'd0);
        else check("rand_res", 64'(out_int), 64'(exp_q.pop_front()));
      end
      if (in_valid && in_ready) begin
        accepted++;
        exp_q.push_back(model(in_L3));
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 4*(AD+2); cyc++) begin
      #1;
      if (out_valid) begin
        received++;
        if (exp_q.size() == 0) check("drain_spurious", 64'd1, 64'd0);
        else check("drain_res", 64'(out_int), 64'(exp_q.pop_front()));
      end
      @(posedge clk);
      #1;
    end
    check("rand_left", 64'(exp_q.size()), 64'd0);
    check("rand_count", 64'(received), 64'(accepted));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
